// File: rtl/dither_pkg.sv
// Shared types and width helpers for the dithered pixel packer.
package dither_pkg;

    localparam int unsigned PKG_PACK_W = 8;
    localparam int unsigned PKG_DATA_W = 3 * PKG_PACK_W;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_bits_t;

    typedef struct packed {
        logic [PKG_DATA_W-1:0] data;
        logic                  eol;
        logic                  eof;
    } packer_word_t;

    typedef enum logic {
        ACTIVE = 1'b0,
        DRAIN  = 1'b1
    } packer_state_t;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/packer_fifo.sv
// Synchronous FIFO for packed words; head is zero while empty, no bypass.
module packer_fifo #(
    parameter int unsigned WIDTH = 26,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_valid = (count != '0);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/dither_pixel_packer.sv
// Packs dithered RGB pixel bits into per-channel words tagged with eol/eof.
// Optional DITHER_PACKER_PARITY_EN adds a per-word parity output and an error-inject input.
module dither_pixel_packer
    import dither_pkg::*;
#(
    parameter int unsigned IMAGEX     = 64,
    parameter int unsigned IMAGEY     = 64,
    parameter int unsigned PACK_W     = PKG_PACK_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_bits,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3*PACK_W-1:0] out_data,
    output logic                out_eol,
    output logic                out_eof,
    output logic                frame_done
`ifdef DITHER_PACKER_PARITY_EN
    ,
    output logic                out_parity,
    input  logic                par_err_inject
`endif
);

    localparam int unsigned CW     = cnt_w(IMAGEX);
    localparam int unsigned RW     = cnt_w(IMAGEY);
    localparam int unsigned PW     = cnt_w(PACK_W);
    localparam int unsigned FCW    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned WORD_W = $bits(packer_word_t);
`ifdef DITHER_PACKER_PARITY_EN
    localparam int unsigned FIFO_W = WORD_W + 1;
`else
    localparam int unsigned FIFO_W = WORD_W;
`endif

    packer_state_t     state;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [PW-1:0]     pos;
    logic [PACK_W-1:0] sh_r, sh_g, sh_b;
    logic [PACK_W-1:0] word_r, word_g, word_b;

    rgb_bits_t         pix;
    logic              accept;
    logic              last_col;
    logic              last_row;
    logic              grp_full;
    logic              push;
    logic              push_eof;
    logic              pop;
    logic              eof_pop;
    logic              active_nxt;
    logic [FCW-1:0]    count;
    logic [FCW-1:0]    count_nxt;
    logic              head_valid;
    packer_word_t      push_word;
    packer_word_t      head_word;
    logic [FIFO_W-1:0] push_entry;
    logic [FIFO_W-1:0] head_entry;

    assign pix      = rgb_bits_t'(in_bits);
    assign accept   = in_valid && in_ready;
    assign last_col = (col == CW'(IMAGEX - 1));
    assign last_row = (row == RW'(IMAGEY - 1));
    assign grp_full = (pos == PW'(PACK_W - 1));
    assign push     = accept && (grp_full || last_col);
    assign push_eof = push && last_col && last_row;

    // Current pixel merged into the partial word; unused upper bits stay zero.
    assign word_r = sh_r | (PACK_W'(pix.r) << pos);
    assign word_g = sh_g | (PACK_W'(pix.g) << pos);
    assign word_b = sh_b | (PACK_W'(pix.b) << pos);

    always_comb begin
        push_word      = '0;
        push_word.data = {word_r, word_g, word_b};
        push_word.eol  = last_col;
        push_word.eof  = last_col && last_row;
    end

`ifdef DITHER_PACKER_PARITY_EN
    assign push_entry = {(^push_word.data) ^ par_err_inject, push_word};
    assign head_word  = packer_word_t'(head_entry[WORD_W-1:0]);
    assign out_parity = head_entry[FIFO_W-1];
`else
    assign push_entry = push_word;
    assign head_word  = packer_word_t'(head_entry);
`endif

    assign pop       = head_valid && out_ready;
    assign eof_pop   = pop && head_word.eof;
    assign count_nxt = count + FCW'(push) - FCW'(pop);

    assign out_valid = head_valid;
    assign out_data  = head_word.data;
    assign out_eol   = head_word.eol;
    assign out_eof   = head_word.eof;

    // Shift registers and column/row position within the frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_r <= '0;
            sh_g <= '0;
            sh_b <= '0;
            pos  <= '0;
            col  <= '0;
            row  <= '0;
        end else if (accept) begin
            if (push) begin
                sh_r <= '0;
                sh_g <= '0;
                sh_b <= '0;
                pos  <= '0;
            end else begin
                sh_r <= word_r;
                sh_g <= word_g;
                sh_b <= word_b;
                pos  <= pos + PW'(1);
            end
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    assign active_nxt = ((state == ACTIVE) && !push_eof) || ((state == DRAIN) && eof_pop);

    // Frame FSM; in_ready is loaded with the value implied by next-cycle state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ACTIVE;
            in_ready   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= eof_pop;
            in_ready   <= active_nxt && (count_nxt < FCW'(FIFO_DEPTH));
            case (state)
                ACTIVE:  if (push_eof) state <= DRAIN;
                DRAIN:   if (eof_pop)  state <= ACTIVE;
                default: state <= ACTIVE;
            endcase
        end
    end

    packer_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .head_data  (head_entry),
        .head_valid (head_valid),
        .count      (count)
    );

endmodule

// File: tb/tb_dither_pixel_packer.sv
// Scoreboard bench for dither_pixel_packer (IMAGEX=10, IMAGEY=4, PACK_W=8, FIFO_DEPTH=4).
module tb_dither_pixel_packer;

    localparam int unsigned IMAGEX     = 10;
    localparam int unsigned IMAGEY     = 4;
    localparam int unsigned PACK_W     = 8;
    localparam int unsigned FIFO_DEPTH = 4;

    typedef struct packed {
        logic [23:0] data;
        logic        eol;
        logic        eof;
        logic        par;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_bits;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        out_eol;
    logic        out_eof;
    logic        frame_done;
`ifdef DITHER_PACKER_PARITY_EN
    logic        out_parity;
    logic        par_err_inject;
`endif

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   fd_seen = 0;

    dither_pixel_packer #(
        .IMAGEX     (IMAGEX),
        .IMAGEY     (IMAGEY),
        .PACK_W     (PACK_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bits    (in_bits),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
        .frame_done (frame_done)
`ifdef DITHER_PACKER_PARITY_EN
        ,
        .out_parity     (out_parity),
        .par_err_inject (par_err_inject)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [23:0] data, input logic eol, input logic eof,
                               input logic inj);
        exp_t e;
        e.data = data;
        e.eol  = eol;
        e.eof  = eof;
        e.par  = (^data) ^ inj;
        sb.push_back(e);
    endtask

    // Present one pixel and return just after the edge that accepts it.
    task automatic send(input logic [2:0] b);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_bits  = b;
        while (!in_ready && g < 200) begin
            tick(1);
            g++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at 0");
        end
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic send_n(input int n, input logic [2:0] b);
        for (int i = 0; i < n; i++) send(b);
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((out_valid || !in_ready) && g < 100) begin
            tick(1);
            g++;
        end
        if (out_valid || !in_ready) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: out_valid=%0b in_ready=%0b", out_valid, in_ready);
        end
        tick(1);
    endtask

    // Monitor: pops the scoreboard on each handshake, checks hold stability and frame_done.
    logic        prev_hold = 1'b0;
    logic [25:0] prev_word = '0;
    logic        fd_expect = 1'b0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (!rst) begin
            prev_hold = 1'b0;
            fd_expect = 1'b0;
        end else begin
            checks++;
            if (frame_done !== fd_expect) begin
                errors++;
                $display("FAIL frame_done: got %0b expected %0b", frame_done, fd_expect);
            end
            if (frame_done) fd_seen++;
            if (prev_hold) begin
                checks++;
                if ({out_valid, out_eol, out_data, out_eof} !== {1'b1, prev_word}) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%0b d=%h eol=%0b eof=%0b held d=%h",
                             out_valid, out_data, out_eol, out_eof, prev_word[24:1]);
                end
            end
            fd_expect = 1'b0;
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got d=%h with empty scoreboard", out_data);
                end else begin
                    mon_e = sb.pop_front();
                    if ({out_data, out_eol, out_eof} !== {mon_e.data, mon_e.eol, mon_e.eof}) begin
                        errors++;
                        $display("FAIL word: got d=%h eol=%0b eof=%0b expected d=%h eol=%0b eof=%0b",
                                 out_data, out_eol, out_eof, mon_e.data, mon_e.eol, mon_e.eof);
                    end
`ifdef DITHER_PACKER_PARITY_EN
                    checks++;
                    if (out_parity !== mon_e.par) begin
                        errors++;
                        $display("FAIL parity: got %0b expected %0b (d=%h)",
                                 out_parity, mon_e.par, mon_e.data);
                    end
`endif
                    fd_expect = mon_e.eof;
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_word = {out_eol, out_data, out_eof};
        end
    end

    logic [9:0] rpat;

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_bits   = 3'b000;
        out_ready = 1'b0;
`ifdef DITHER_PACKER_PARITY_EN
        par_err_inject = 1'b0;
`endif
        rpat = 10'b01_1000_1101;

        // Reset values
        tick(3);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_flags", 32'({out_eol, out_eof, frame_done}), 32'd0);
        rst = 1'b1;
        tick(1);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Frame 1: R pattern on row 0, then all-ones rows
        out_ready = 1'b1;
        expect_word(24'h8DFF00, 1'b0, 1'b0, 1'b0);
        expect_word(24'h010300, 1'b1, 1'b0, 1'b0);
        for (int r = 1; r < 4; r++) begin
            expect_word(24'hFFFFFF, 1'b0, 1'b0, 1'b0);
            expect_word(24'h030303, 1'b1, (r == 3), 1'b0);
        end
        for (int c = 0; c < 10; c++) send({rpat[c], 1'b1, 1'b0});
        send_n(29, 3'b111);
        send(3'b111);
        check("drain_in_ready", 32'(in_ready), 32'd0);
        check("drain_out_eof", 32'({out_valid, out_eof}), 32'b11);
        wait_drain();

        // Frame 2: head hold, push and pop together at count 1
        out_ready = 1'b0;
        expect_word(24'hFFFFFF, 1'b0, 1'b0, 1'b0);
        send_n(8, 3'b111);
        tick(3);
        check("hold_head", 32'({out_valid, out_data}), {7'd0, 1'b1, 24'hFFFFFF});
        expect_word(24'h030303, 1'b1, 1'b0, 1'b0);
        send(3'b111);
        out_ready = 1'b1;
        send(3'b111);
        out_ready = 1'b0;
        check("pushpop_head", 32'({out_valid, out_eol, out_data}), {6'd0, 2'b11, 24'h030303});
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("pushpop_count1", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        for (int r = 1; r < 4; r++) begin
            expect_word(24'hFFFFFF, 1'b0, 1'b0, 1'b0);
            expect_word(24'h030303, 1'b1, (r == 3), 1'b0);
        end
        send_n(30, 3'b111);
        wait_drain();

        // Frame 3: backpressure with a full FIFO
        out_ready = 1'b0;
        expect_word(24'hFF0000, 1'b0, 1'b0, 1'b0);
        expect_word(24'h030000, 1'b1, 1'b0, 1'b0);
        expect_word(24'h00FF00, 1'b0, 1'b0, 1'b0);
        expect_word(24'h000300, 1'b1, 1'b0, 1'b0);
        expect_word(24'h0000FF, 1'b0, 1'b0, 1'b0);
        expect_word(24'h000003, 1'b1, 1'b0, 1'b0);
        expect_word(24'hFF00FF, 1'b0, 1'b0, 1'b0);
        expect_word(24'h030003, 1'b1, 1'b1, 1'b0);
        send_n(10, 3'b100);
        send_n(9, 3'b010);
        check("bp_not_full", 32'(in_ready), 32'd1);
        send(3'b010);
        check("bp_full", 32'(in_ready), 32'd0);
        tick(2);
        check("bp_hold", 32'({in_ready, out_valid}), 32'b01);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("bp_release", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        send_n(10, 3'b001);
        send_n(10, 3'b101);
        wait_drain();

        // Reset mid-row discards the queued word and partial state
        out_ready = 1'b0;
        send_n(13, 3'b111);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b0;
        sb.delete();
        #2;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        tick(1);
        rst = 1'b1;
        tick(1);
        check("midrst_release_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        expect_word(24'hFFFF00, 1'b0, 1'b0, 1'b0);
        send_n(8, 3'b110);
        wait_drain();

`ifdef DITHER_PACKER_PARITY_EN
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        expect_word(24'hFF0100, 1'b0, 1'b0, 1'b0);
        expect_word(24'h000000, 1'b1, 1'b0, 1'b0);
        expect_word(24'hFF0100, 1'b0, 1'b0, 1'b1);
        send(3'b110);
        send_n(7, 3'b100);
        send_n(2, 3'b000);
        send(3'b110);
        send_n(6, 3'b100);
        par_err_inject = 1'b1;
        send(3'b100);
        par_err_inject = 1'b0;
        wait_drain();
`endif

        tick(3);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("frame_done_count", 32'(fd_seen), 32'd3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dither_pixel_packer.md
Name: dither_pixel_packer

Overview:
- Downstream of the per-channel pixel algorithm units.
- Consumes one dithered pixel per accepted beat, carrying one result bit each for R, G and B.
- Packs PACK_W consecutive pixels of a row into one word per channel, tags each word with end-of-line and end-of-frame, and buffers words in a small FIFO.
- Output is a valid/ready stream toward the display or memory writer.

Parameters:
- IMAGEX, 64, pixels per row.
- IMAGEY, 64, rows per frame.
- PACK_W, 8, pixels packed per output word per channel.
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately.
- in_valid  input  1  upstream pixel bits valid.
- in_ready  output  1  packer accepts the pixel this cycle.
- in_bits  input  3  dithered pixel bits: [2]=R, [1]=G, [0]=B.
- out_valid  output  1  FIFO head word valid.
- out_ready  input  1  downstream consumes the head word.
- out_data  output  3*PACK_W  word layout: [3*PACK_W-1:2*PACK_W]=R, next PACK_W bits=G, low PACK_W bits=B.
- out_eol  output  1  head word is the last word of its row.
- out_eof  output  1  head word is the last word of the frame.
- frame_done  output  1  one-cycle pulse when the last word of a frame leaves the FIFO.

Behaviour:
- Reset values:
  - in_ready=0 during reset, 1 on the first cycle after release.
  - out_valid=0, out_data=0, out_eol=0, out_eof=0, frame_done=0.
  - Column and row counters = 0; shift registers = 0; FIFO empty; FSM = ACTIVE.
- Accept rule: a pixel is accepted on any edge where in_valid && in_ready.
- Packing:
  - Accepted pixel bits shift into per-channel registers, LSB first: column c lands at bit (c mod PACK_W).
  - The column counter increments per accepted pixel.
- Word completion: a word is pushed to the FIFO on the same edge that accepts either:
  - the PACK_W-th pixel of the group, or
  - the last pixel of a row (column = IMAGEX-1).
  - A partial final word is zero-padded in its unused upper bits.
  - The shift registers clear on push.
- Flags and counters:
  - out_eol=1 on words completed at column IMAGEX-1.
  - out_eof=1 additionally when row = IMAGEY-1.
  - On the end-of-row push, the column counter wraps to 0 and the row counter increments.
  - On the end-of-frame push, the row counter wraps to 0.
- Latency: a pushed word appears at the FIFO head (out_valid=1) on the cycle after the completing pixel is accepted. There is no bypass path.
- Backpressure:
  - in_ready = FSM in ACTIVE && FIFO count < FIFO_DEPTH, computed from registered state.
  - A push into a full FIFO is therefore impossible.
- FIFO:
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop keeps the count unchanged, including at count=1.
  - out_* fields hold stable while out_valid && !out_ready.
- FSM:
  - ACTIVE → DRAIN on the edge that pushes the eof word.
  - DRAIN: in_ready=0. When the eof word pops, frame_done pulses on that same cycle (registered on the next edge), and the FSM returns to ACTIVE on the next edge.
  - Back-to-back frames are separated by at least one idle input cycle.
- Reset mid-frame: all partial words, FIFO contents and counters are discarded. The next accepted pixel is column 0, row 0.
- in_valid while in_ready=0: ignored, no state change.

Optional Feature:
- Macro: DITHER_PACKER_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = XOR of all bits of out_data, stored per FIFO entry.
  - Adds input port par_err_inject; when it is 1 at push time, the stored parity is inverted.
- Undefined: neither port exists, and the FIFO width excludes the parity bit.

Decomposition:
- Package dither_pkg holds:
  - typedef rgb_bits_t (3-bit packed struct with r, g, b fields);
  - typedef packer_word_t (data, eol, eof);
  - enum packer_state_t {ACTIVE, DRAIN};
  - localparam function clog2-based counter widths.
- One sub-module, packer_fifo: a synchronous FIFO parameterised by width and depth, async active-low reset, count output.

Test Plan:
- Basic pack (IMAGEX=8, IMAGEY=1, out_ready=1):
  - Stimulus: in_bits R pattern 1,0,1,1,0,0,0,1; G all 1; B all 0.
  - Response: one word, R=8'b1000_1101, G=8'hFF, B=8'h00; eol=1, eof=1; frame_done pulses once.
- Row padding (IMAGEX=10, PACK_W=8, IMAGEY=2, all bits 1):
  - Response: four words with R fields FF, 03, FF, 03.
  - eol on words 2 and 4; eof only on word 4.
- Backpressure (FIFO_DEPTH=4, out_ready=0, IMAGEX=64):
  - in_ready drops after 4 words (32 pixels).
  - Then assert out_ready for 1 cycle: in_ready returns to 1 on the next cycle, and no word is lost or duplicated.
- Simultaneous push/pop at count=1:
  - Count stays 1 and ordering is preserved.
  - out_data is stable while out_ready=0.
- Reset mid-operation:
  - Assert rst=0 after 13 pixels of row 0, then release.
  - out_valid=0 immediately; the next 8 pixels produce a word with eol=0 corresponding to column 0.
- DITHER_PACKER_PARITY_EN:
  - Word R=FF, G=01, B=00 gives out_parity=1.
  - With par_err_inject=1 at push, out_parity=0.
